// File: rtl/car_access_if.sv
// Bus between the car access sequencer and its environment: detector/switch
// inputs in, LED flags, fail counter and state glyph out.
interface car_access_if;
  logic       key_ok;
  logic       bad_code;
  logic       door_open;
  logic       ign_req;
  logic       lock_req;
  logic       unlocked;
  logic       engine_on;
  logic       alarm;
  logic       lockout;
  logic [2:0] fail_cnt;
  logic [2:0] state_code;
  logic [7:0] seg;

  modport master (
    output key_ok, bad_code, door_open, ign_req, lock_req,
    input  unlocked, engine_on, alarm, lockout, fail_cnt, state_code, seg
  );

  modport slave (
    input  key_ok, bad_code, door_open, ign_req, lock_req,
    output unlocked, engine_on, alarm, lockout, fail_cnt, state_code, seg
  );
endinterface

// File: rtl/car_access_controller.sv
// Vehicle access sequencer: locked/unlocked/running/lockout/alarm with cycle
// timers, driven by the key-code detector and board switches.
module car_access_controller #(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned UNLOCK_TIMEOUT = 10,
  parameter int unsigned LOCKOUT_CYCLES = 20,
  parameter int unsigned ALARM_CYCLES   = 15
) (
  input  logic         clk_2,
  input  logic         reset,
  car_access_if.slave  bus
);

  localparam int unsigned TMAX_A    = (UNLOCK_TIMEOUT > LOCKOUT_CYCLES) ? UNLOCK_TIMEOUT : LOCKOUT_CYCLES;
  localparam int unsigned TIMER_MAX = (TMAX_A > ALARM_CYCLES) ? TMAX_A : ALARM_CYCLES;
  localparam int unsigned TW        = $clog2(TIMER_MAX);
  localparam int unsigned FW        = 3;

  typedef enum logic [2:0] {
    ST_LOCKED   = 3'd0,
    ST_UNLOCKED = 3'd1,
    ST_RUNNING  = 3'd2,
    ST_LOCKOUT  = 3'd3,
    ST_ALARM    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic            key_q;
  logic            key_rise;
  logic            unlocked_q, engine_on_q, alarm_q, lockout_q;

  assign key_rise = bus.key_ok & ~key_q;

  // State, timer, counter and flag registers; flags follow the next state so
  // they line up with state_code.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOCKED;
      timer_q     <= '0;
      fail_q      <= '0;
      key_q       <= 1'b0;
      unlocked_q  <= 1'b0;
      engine_on_q <= 1'b0;
      alarm_q     <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      fail_q      <= fail_d;
      key_q       <= bus.key_ok;
      unlocked_q  <= (state_d == ST_UNLOCKED) || (state_d == ST_RUNNING);
      engine_on_q <= (state_d == ST_RUNNING);
      alarm_q     <= (state_d == ST_ALARM);
      lockout_q   <= (state_d == ST_LOCKOUT);
    end
  end

  // Next-state, timer and fail counter
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    unique case (state_q)
      ST_LOCKED: begin
        timer_d = '0;
        if (key_rise) begin
          state_d = ST_UNLOCKED;
          fail_d  = '0;
        end else if (bus.door_open) begin
          state_d = ST_ALARM;
        end else if (bus.bad_code) begin
          if (fail_q != FW'(MAX_TRIES)) fail_d = fail_q + FW'(1);
          if (fail_d == FW'(MAX_TRIES)) state_d = ST_LOCKOUT;
        end
      end
      ST_UNLOCKED: begin
        if (bus.lock_req && !bus.door_open) begin
          state_d = ST_LOCKED;
        end else if (bus.ign_req && !bus.door_open) begin
          state_d = ST_RUNNING;
        end else if (bus.door_open) begin
          timer_d = '0;
        end else if (timer_q == TW'(UNLOCK_TIMEOUT - 1)) begin
          state_d = ST_LOCKED;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RUNNING: begin
        timer_d = '0;
        if (!bus.ign_req) state_d = ST_UNLOCKED;
      end
      ST_LOCKOUT: begin
        if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_ALARM: begin
        if (key_rise) begin
          state_d = ST_UNLOCKED;
          fail_d  = '0;
        end else if (timer_q == TW'(ALARM_CYCLES - 1)) begin
          state_d = ST_LOCKED;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_LOCKED;
        timer_d = '0;
      end
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  // Seven-segment glyph of the current state
  always_comb begin
    bus.seg = 8'b00111000;
    unique case (state_q)
      ST_LOCKED:   bus.seg = 8'b00111000;
      ST_UNLOCKED: bus.seg = 8'b00111110;
      ST_RUNNING:  bus.seg = 8'b01010000;
      ST_LOCKOUT:  bus.seg = 8'b01110110;
      ST_ALARM:    bus.seg = 8'b01110111;
      default:     bus.seg = 8'b00111000;
    endcase
  end

  assign bus.unlocked   = unlocked_q;
  assign bus.engine_on  = engine_on_q;
  assign bus.alarm      = alarm_q;
  assign bus.lockout    = lockout_q;
  assign bus.fail_cnt   = fail_q;
  assign bus.state_code = state_q;

endmodule

// File: tb/tb_car_access_controller.sv
// Self-checking bench for car_access_controller: directed scenarios followed
// by random switch activity, compared against a cycle-level behavioural model.
module tb_car_access_controller;

  localparam int MAX_TRIES      = 3;
  localparam int UNLOCK_TIMEOUT = 10;
  localparam int LOCKOUT_CYCLES = 20;
  localparam int ALARM_CYCLES   = 15;

  localparam int LK = 0, UL = 1, RN = 2, LO = 3, AL = 4;

  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  car_access_if bus();

  car_access_controller dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2 = ~clk_2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: current state, cycles spent idle in it, failed attempts
  int m_state = LK;
  int m_spent = 0;
  int m_fail  = 0;
  bit m_key_prev = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] glyph(input int st);
    case (st)
      UL:      return 8'b00111110;
      RN:      return 8'b01010000;
      LO:      return 8'b01110110;
      AL:      return 8'b01110111;
      default: return 8'b00111000;
    endcase
  endfunction

  task automatic model_reset();
    m_state = LK; m_spent = 0; m_fail = 0; m_key_prev = 1'b0;
  endtask

  task automatic model_step(input bit kok, input bit bc, input bit door, input bit ign, input bit lck);
    bit rise;
    int nxt;
    rise = kok && !m_key_prev;
    m_key_prev = kok;
    nxt = m_state;
    case (m_state)
      LK: if (rise) begin nxt = UL; m_fail = 0; end
          else if (door) nxt = AL;
          else if (bc) begin
            if (m_fail < MAX_TRIES) m_fail = m_fail + 1;
            if (m_fail == MAX_TRIES) nxt = LO;
          end
      UL: if (lck && !door) nxt = LK;
          else if (ign && !door) nxt = RN;
          else if (door) m_spent = 0;
          else begin
            m_spent = m_spent + 1;
            if (m_spent == UNLOCK_TIMEOUT) nxt = LK;
          end
      RN: if (!ign) nxt = UL;
      LO: begin
            m_spent = m_spent + 1;
            if (m_spent == LOCKOUT_CYCLES) begin nxt = LK; m_fail = 0; end
          end
      AL: if (rise) begin nxt = UL; m_fail = 0; end
          else begin
            m_spent = m_spent + 1;
            if (m_spent == ALARM_CYCLES) nxt = LK;
          end
      default: nxt = LK;
    endcase
    if (nxt != m_state) m_spent = 0;
    m_state = nxt;
  endtask

  task automatic compare_all();
    check("state_code", 8'(bus.state_code), 8'(m_state));
    check("unlocked",   8'(bus.unlocked),   8'(m_state == UL || m_state == RN));
    check("engine_on",  8'(bus.engine_on),  8'(m_state == RN));
    check("alarm",      8'(bus.alarm),      8'(m_state == AL));
    check("lockout",    8'(bus.lockout),    8'(m_state == LO));
    check("fail_cnt",   8'(bus.fail_cnt),   8'(m_fail));
    check("seg",        bus.seg,            glyph(m_state));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare
  task automatic step(input bit kok, input bit bc, input bit door, input bit ign, input bit lck);
    bus.key_ok = kok; bus.bad_code = bc; bus.door_open = door;
    bus.ign_req = ign; bus.lock_req = lck;
    @(posedge clk_2);
    model_step(kok, bc, door, ign, lck);
    #1;
    compare_all();
  endtask

  initial begin
    int cnt;
    bit kok, bc, door, ign, lck;

    bus.key_ok = 0; bus.bad_code = 0; bus.door_open = 0; bus.ign_req = 0; bus.lock_req = 0;
    repeat (2) @(posedge clk_2);
    #1;
    model_reset();
    compare_all();
    @(negedge clk_2);
    reset = 1'b0;

    // Unlock, held key must not re-trigger, auto-relock after UNLOCK_TIMEOUT
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    cnt = (bus.state_code == 3'd1) ? 1 : 0;
    for (int i = 0; i < 100 && bus.state_code == 3'd1; i++) begin
      step(1, 0, 0, 0, 0);
      if (bus.state_code == 3'd1) cnt++;
    end
    check("unlock_len", 8'(cnt), 8'(UNLOCK_TIMEOUT));
    repeat (3) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Three wrong codes into lockout; key pulse inside lockout is lost
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("lockout_seg", bus.seg, 8'b01110110);
    cnt = (bus.lockout === 1'b1) ? 1 : 0;
    step(1, 0, 0, 0, 0); if (bus.lockout === 1'b1) cnt++;
    step(0, 0, 0, 0, 0); if (bus.lockout === 1'b1) cnt++;
    for (int i = 0; i < 100 && bus.lockout === 1'b1; i++) begin
      step(0, 0, 0, 0, 0);
      if (bus.lockout === 1'b1) cnt++;
    end
    check("lockout_len", 8'(cnt), 8'(LOCKOUT_CYCLES));
    check("lockout_exit_fail", 8'(bus.fail_cnt), 8'd0);

    // Drive sequence: unlock, run, lock ignored, stop, lock
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("drive_locked", 8'(bus.unlocked), 8'd0);
    step(0, 0, 0, 0, 0);

    // Alarm disarmed by key at alarm cycle 5
    step(0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    check("alarm_disarm", 8'(bus.state_code), 8'd1);
    step(1, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);

    // Alarm runs out, re-enters while door stays open
    step(0, 0, 1, 0, 0);
    cnt = (bus.alarm === 1'b1) ? 1 : 0;
    for (int i = 0; i < 100 && bus.alarm === 1'b1; i++) begin
      step(0, 0, 1, 0, 0);
      if (bus.alarm === 1'b1) cnt++;
    end
    check("alarm_len", 8'(cnt), 8'(ALARM_CYCLES));
    step(0, 0, 1, 0, 0);
    check("alarm_rearm", 8'(bus.state_code), 8'd4);
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);

    // Simultaneous key, bad code and door in LOCKED
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    check("simul_fail", 8'(bus.fail_cnt), 8'd0);
    repeat (UNLOCK_TIMEOUT + 2) step(1, 0, 1, 0, 1);

    // Async reset mid-count in RUNNING
    step(0, 0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 1, 0);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("areset_state", 8'(bus.state_code), 8'd0);
    check("areset_unlocked", 8'(bus.unlocked), 8'd0);
    check("areset_engine", 8'(bus.engine_on), 8'd0);
    check("areset_seg", bus.seg, 8'b00111000);
    bus.ign_req = 0;
    @(posedge clk_2);
    #4 reset = 1'b0;
    step(0, 0, 0, 0, 0);

    // Random activity against the model
    kok = 0; bc = 0; door = 0; ign = 0; lck = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) kok = ~kok;
      bc = ($urandom_range(6) == 0);
      if ($urandom_range(29) == 0) door = ~door;
      if ($urandom_range(9) == 0) ign = ~ign;
      lck = ($urandom_range(11) == 0);
      step(kok, bc, door, ign, lck);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
